md_iter_unit: RTL

- Parametrised iterative multiply/divide unit for the EX stage; successor to the fixed 32-bit divider.
- One datapath, shared counter and handshake for MULT, MULTU, DIV and DIVU.
- Returns the {hi, lo} pair and a stall request so EX holds the instruction until the result is ready.
- Operand width is set by parameter.

---
 rtl/md_pkg.sv | 36 +++
 rtl/md_sign_fix.sv | 21 ++
 rtl/md_iter_unit.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// -----------------------------------------------------------------------------
// md_pkg
// Shared definitions for the iterative multiply/divide unit:
//   - operation encodings (op_i field of md_iter_unit)
//   - FSM state encoding
//   - stall request levels
//   - small op-decode helpers
// -----------------------------------------------------------------------------
package md_pkg;

   typedef enum logic [1:0] {
      MD_MULTU = 2'b00,
      MD_MULT  = 2'b01,
      MD_DIVU  = 2'b10,
      MD_DIV   = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'b00,
      MD_CALC = 2'b01,
      MD_DONE = 2'b10
   } md_state_e;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   // op[0] selects the signed variant, op[1] selects divide.
   function automatic logic op_is_signed(input logic [1:0] op);
      return op[0];
   endfunction

   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/md_sign_fix.sv
// -----------------------------------------------------------------------------
// md_sign_fix
// Conditional two's-complement negate.
// Ports:
//   neg_i   in   1      negate when high
//   data_i  in   WIDTH  input value
//   data_o  out  WIDTH  neg_i ? -data_i : data_i
// -----------------------------------------------------------------------------
module md_sign_fix #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             neg_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o
);

   always_comb begin
      data_o = neg_i ? (~data_i + WIDTH'(1)) : data_i;
   end

endmodule

// File: rtl/md_iter_unit.sv
// -----------------------------------------------------------------------------
// md_iter_unit
// Iterative multiply/divide unit for the EX stage. One shift datapath and one
// counter serve MULTU/MULT (shift-add) and DIVU/DIV (restoring, MSB first).
// Signed ops work on magnitudes; the result is sign-corrected on the last
// iteration.
// Ports:
//   clk          in   1      clock, rising edge
//   resetn       in   1      asynchronous active-low reset
//   start_i      in   1      request, held while the instruction sits in EX
//   op_i         in   2      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   src_a_i      in   WIDTH  multiplicand / dividend
//   src_b_i      in   WIDTH  multiplier / divisor
//   annul_i      in   1      abort current operation
//   stallreq_o   out  1      pipeline stall request
//   busy_o       out  1      unit not idle
//   ready_o      out  1      result valid (one-cycle pulse)
//   dbz_o        out  1      divide by zero, valid with ready_o
//   result_hi_o  out  WIDTH  product high half / remainder
//   result_lo_o  out  WIDTH  product low half / quotient
// -----------------------------------------------------------------------------
module md_iter_unit
   import md_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start_i,
   input  logic [1:0]       op_i,
   input  logic [WIDTH-1:0] src_a_i,
   input  logic [WIDTH-1:0] src_b_i,
   input  logic             annul_i,
   output logic             stallreq_o,
   output logic             busy_o,
   output logic             ready_o,
   output logic             dbz_o,
   output logic [WIDTH-1:0] result_hi_o,
   output logic [WIDTH-1:0] result_lo_o
);

   md_state_e          state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               div_q;
   logic               neg_res_q;   // operand signs differ
   logic               neg_rem_q;   // dividend negative
   logic [WIDTH-1:0]   opb_q;       // multiplicand / divisor magnitude
   logic [2*WIDTH-1:0] acc_q;       // working {hi, lo}; final result while in DONE
   logic [WIDTH-1:0]   hold_hi_q;
   logic [WIDTH-1:0]   hold_lo_q;
   logic               dbz_q;

   // Operand magnitudes
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] mag_a, mag_b;

   assign a_neg = op_is_signed(op_i) & src_a_i[WIDTH-1];
   assign b_neg = op_is_signed(op_i) & src_b_i[WIDTH-1];

   md_sign_fix #(.WIDTH(WIDTH)) u_fix_a (.neg_i(a_neg), .data_i(src_a_i), .data_o(mag_a));
   md_sign_fix #(.WIDTH(WIDTH)) u_fix_b (.neg_i(b_neg), .data_i(src_b_i), .data_o(mag_b));

   // One iteration of either algorithm
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_top;
   logic [WIDTH:0]     div_diff;
   logic               div_ge;
   logic [WIDTH-1:0]   div_rem;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] step_next;

   always_comb begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
               + {1'b0, (acc_q[0] ? opb_q : {WIDTH{1'b0}})};
      mul_next = {mul_sum, acc_q[WIDTH-1:1]};

      // Partial remainder shifted left with the next dividend bit. It stays
      // below 2*divisor, so bit WIDTH of the difference is a valid borrow.
      div_top  = acc_q[2*WIDTH-1:WIDTH-1];
      div_diff = div_top - {1'b0, opb_q};
      div_ge   = ~div_diff[WIDTH];
      div_rem  = div_ge ? div_diff[WIDTH-1:0] : div_top[WIDTH-1:0];
      div_next = {div_rem, acc_q[WIDTH-2:0], div_ge};

      step_next = div_q ? div_next : mul_next;
   end

   // Result correction. The 2*WIDTH negate also yields -quotient in its low half.
   logic [2*WIDTH-1:0] fix_full;
   logic [WIDTH-1:0]   fix_rem;
   logic [2*WIDTH-1:0] final_res;

   md_sign_fix #(.WIDTH(2 * WIDTH)) u_fix_res (
      .neg_i  (neg_res_q),
      .data_i (step_next),
      .data_o (fix_full)
   );
   md_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
      .neg_i  (neg_rem_q),
      .data_i (step_next[2*WIDTH-1:WIDTH]),
      .data_o (fix_rem)
   );

   assign final_res = div_q ? {fix_rem, fix_full[WIDTH-1:0]} : fix_full;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= MD_IDLE;
         cnt_q     <= '0;
         div_q     <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         opb_q     <= '0;
         acc_q     <= '0;
         hold_hi_q <= '0;
         hold_lo_q <= '0;
         dbz_q     <= 1'b0;
      end else begin
         unique case (state_q)
            MD_IDLE: begin
               if (start_i && !annul_i) begin
                  div_q     <= op_is_div(op_i);
                  neg_res_q <= a_neg ^ b_neg;
                  neg_rem_q <= a_neg;
                  opb_q     <= mag_b;
                  cnt_q     <= CNT_W'(WIDTH);
                  if (op_is_div(op_i) && (src_b_i == '0)) begin
                     acc_q   <= {src_a_i, {WIDTH{1'b1}}};
                     dbz_q   <= 1'b1;
                     state_q <= MD_DONE;
                  end else begin
                     acc_q   <= {{WIDTH{1'b0}}, mag_a};
                     dbz_q   <= 1'b0;
                     state_q <= MD_CALC;
                  end
               end
            end
            MD_CALC: begin
               cnt_q <= cnt_q - CNT_W'(1);
               if (annul_i) begin
                  cnt_q   <= '0;
                  state_q <= MD_IDLE;
               end else if (cnt_q == CNT_W'(1)) begin
                  acc_q   <= final_res;
                  state_q <= MD_DONE;
               end else begin
                  acc_q <= step_next;
               end
            end
            MD_DONE: begin
               state_q <= MD_IDLE;
               if (annul_i) begin
                  dbz_q <= 1'b0;
               end else begin
                  hold_hi_q <= acc_q[2*WIDTH-1:WIDTH];
                  hold_lo_q <= acc_q[WIDTH-1:0];
               end
            end
            default: state_q <= MD_IDLE;
         endcase
      end
   end

   always_comb begin
      ready_o     = (state_q == MD_DONE) & ~annul_i;
      busy_o      = (state_q != MD_IDLE);
      dbz_o       = dbz_q;
      // The fresh result is visible in DONE; afterwards the committed copy.
      result_hi_o = (state_q == MD_DONE) ? acc_q[2*WIDTH-1:WIDTH] : hold_hi_q;
      result_lo_o = (state_q == MD_DONE) ? acc_q[WIDTH-1:0] : hold_lo_q;
      stallreq_o  = (start_i & ~ready_o & ~annul_i) ? STOP : NO_STOP;
   end

endmodule
